// File: rtl/conv_stream_driver.sv
// conv_stream_driver: host-loaded x/f vector source and y result sink for the 1-D convolution core, with run latency count.
module conv_stream_driver #(
  parameter int DATA_N      = 8,
  parameter int LG_DATA_N   = 3,
  parameter int FILTER_N    = 4,
  parameter int LG_FILTER_N = 2,
  parameter int CONV_N      = 5,
  parameter int LG_CONV_N   = 3,
  parameter int DATA_W      = 8,
  parameter int Y_W         = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [LG_DATA_N-1:0] ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          cycles,
  output logic                 m_valid_x,
  output logic [DATA_W-1:0]    m_data_x,
  input  logic                 s_ready_x,
  output logic                 m_valid_f,
  output logic [DATA_W-1:0]    m_data_f,
  input  logic                 s_ready_f,
  input  logic                 s_valid_y,
  input  logic [Y_W-1:0]       s_data_y,
  output logic                 m_ready_y,
  input  logic [LG_CONV_N-1:0] rd_addr,
  output logic [Y_W-1:0]       rd_data
);
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  state_t                 state_q, state_d;
  logic [LG_DATA_N:0]     cnt_x_q, cnt_x_d;
  logic [LG_FILTER_N:0]   cnt_f_q, cnt_f_d;
  logic [LG_CONV_N-1:0]   cnt_y_q, cnt_y_d;
  logic [15:0]            cycles_q, cycles_d;
  logic [DATA_W-1:0]      x_buf_q [DATA_N];
  logic [DATA_W-1:0]      f_buf_q [FILTER_N];
  logic [Y_W-1:0]         y_buf_q [CONV_N];
  logic                   fire_x, fire_f, fire_y;
  assign busy      = state_q == SEND || state_q == RECV;
  assign done      = state_q == DONE;
  assign m_ready_y = state_q == RECV;
  assign m_valid_x = state_q == SEND && cnt_x_q < (LG_DATA_N+1)'(DATA_N);
  assign m_valid_f = state_q == SEND && cnt_f_q < (LG_FILTER_N+1)'(FILTER_N);
  // Data is gated by valid so the channels idle at zero; the counter only moves on acceptance, keeping data stable.
  assign m_data_x  = m_valid_x ? x_buf_q[cnt_x_q[LG_DATA_N-1:0]] : '0;
  assign m_data_f  = m_valid_f ? f_buf_q[cnt_f_q[LG_FILTER_N-1:0]] : '0;
  assign fire_x    = m_valid_x & s_ready_x;
  assign fire_f    = m_valid_f & s_ready_f;
  assign fire_y    = m_ready_y & s_valid_y;
  assign rd_data   = int'(rd_addr) < CONV_N ? y_buf_q[rd_addr] : '0;
  assign cycles    = cycles_q;
  always_comb begin
    state_d  = state_q;
    cnt_x_d  = cnt_x_q + (LG_DATA_N+1)'(fire_x);
    cnt_f_d  = cnt_f_q + (LG_FILTER_N+1)'(fire_f);
    cnt_y_d  = cnt_y_q + LG_CONV_N'(fire_y);
    cycles_d = busy && cycles_q != 16'hFFFF ? cycles_q + 16'd1 : cycles_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = SEND;
        cnt_x_d  = '0;
        cnt_f_d  = '0;
        cnt_y_d  = '0;
        cycles_d = '0;
      end
      SEND: state_d = cnt_x_d == (LG_DATA_N+1)'(DATA_N) && cnt_f_d == (LG_FILTER_N+1)'(FILTER_N) ? RECV : SEND;
      RECV: state_d = fire_y && cnt_y_q == LG_CONV_N'(CONV_N-1) ? DONE : RECV;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_x_q  <= '0;
      cnt_f_q  <= '0;
      cnt_y_q  <= '0;
      cycles_q <= '0;
      for (int i = 0; i < DATA_N; i++) x_buf_q[i] <= '0;
      for (int i = 0; i < FILTER_N; i++) f_buf_q[i] <= '0;
      for (int i = 0; i < CONV_N; i++) y_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_x_q  <= cnt_x_d;
      cnt_f_q  <= cnt_f_d;
      cnt_y_q  <= cnt_y_d;
      cycles_q <= cycles_d;
      if (state_q == IDLE && ld_en && !ld_sel && int'(ld_addr) < DATA_N) x_buf_q[ld_addr] <= ld_data;
      if (state_q == IDLE && ld_en && ld_sel && int'(ld_addr) < FILTER_N) f_buf_q[ld_addr[LG_FILTER_N-1:0]] <= ld_data;
      if (fire_y) y_buf_q[cnt_y_q] <= s_data_y;
    end
  end
endmodule

// File: tb/tb_conv_stream_driver.sv
// tb_conv_stream_driver: directed bench with a cycle-level core model for conv_stream_driver.
module tb_conv_stream_driver;
  logic        clk, reset_n, ld_en, ld_sel, start;
  logic [2:0]  ld_addr, rd_addr;
  logic [7:0]  ld_data, m_data_x, m_data_f;
  logic        busy, done, m_valid_x, m_valid_f, s_ready_x, s_ready_f, s_valid_y, m_ready_y;
  logic [15:0] cycles;
  logic [17:0] s_data_y, rd_data;
  int          checks, failures;
  logic [7:0]  xv [8];
  logic [7:0]  fv [4];
  logic [17:0] yv [5];
  logic [7:0]  rx_x [8];
  logic [7:0]  rx_f [4];
  int          r_cyc, r_busy, r_y, r_xi, r_fi;
  bit          r_done, r_stab_bad, r_recv_bad, r_ysend_bad, r_first_bad;
  conv_stream_driver dut (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .busy(busy), .done(done), .cycles(cycles),
    .m_valid_x(m_valid_x), .m_data_x(m_data_x), .s_ready_x(s_ready_x),
    .m_valid_f(m_valid_f), .m_data_f(m_data_f), .s_ready_f(s_ready_f),
    .s_valid_y(s_valid_y), .s_data_y(s_data_y), .m_ready_y(m_ready_y),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic ld(input bit sel, input int a, input int d);
    @(negedge clk);
    ld_en = 1; ld_sel = sel; ld_addr = 3'(a); ld_data = 8'(d);
    @(negedge clk);
    ld_en = 0;
  endtask
  task automatic load_all();
    for (int i = 0; i < 8; i++) ld(0, i, int'(xv[i]));
    for (int i = 0; i < 4; i++) ld(1, i, int'(fv[i]));
  endtask
  task automatic rdc(input string tag, input int a, input logic [17:0] exp);
    @(negedge clk);
    rd_addr = 3'(a);
    #1 check(tag, 32'(rd_data), 32'(exp));
  endtask
  // Drives start, then plays the core: x/f sink with optional random backpressure, y source of ny beats.
  task automatic run(input bit bp, input int ny, input bit poke, input bit gap);
    int n, lim;
    bit pvx, pvf;
    logic [7:0] pdx, pdf;
    n = 0; lim = ny < 5 ? 30 : 400; pvx = 0; pvf = 0; pdx = 0; pdf = 0;
    r_cyc = 0; r_busy = 0; r_y = 0; r_xi = 0; r_fi = 0;
    r_done = 0; r_stab_bad = 0; r_recv_bad = 0; r_ysend_bad = 0; r_first_bad = 0;
    @(negedge clk);
    start = 1;
    while (n < lim && !r_done) begin
      @(negedge clk);
      n++;
      start = 0; ld_en = 0;
      s_ready_x = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_ready_f = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid_y = r_y < ny && (!gap || n[0]);
      s_data_y  = yv[r_y < 5 ? r_y : 0];
      if (poke && n == 2) begin
        ld_en = 1; ld_sel = 0; ld_addr = 3'd7; ld_data = 8'hEE;
      end
      if (poke && m_ready_y && r_y == 1) start = 1;
      #1;
      if (n == 1 && !(busy && m_valid_x && m_valid_f && m_data_x === xv[0] && m_data_f === fv[0])) r_first_bad = 1;
      if (pvx && (!m_valid_x || m_data_x !== pdx)) r_stab_bad = 1;
      if (pvf && (!m_valid_f || m_data_f !== pdf)) r_stab_bad = 1;
      pvx = m_valid_x && !s_ready_x; pdx = m_data_x;
      pvf = m_valid_f && !s_ready_f; pdf = m_data_f;
      if (busy) r_busy++;
      if (m_valid_x && s_ready_x) begin
        if (r_xi < 8) rx_x[r_xi] = m_data_x;
        r_xi++;
      end
      if (m_valid_f && s_ready_f) begin
        if (r_fi < 4) rx_f[r_fi] = m_data_f;
        r_fi++;
      end
      if (m_ready_y && (r_xi != 8 || r_fi != 4)) r_recv_bad = 1;
      if (m_ready_y && (m_valid_x || m_valid_f || !busy)) r_ysend_bad = 1;
      if (s_valid_y && m_ready_y) r_y++;
      if (done) begin
        r_done = 1;
        r_cyc = int'(cycles);
        if (busy) r_ysend_bad = 1;
      end
    end
    s_valid_y = 0; start = 0;
  endtask
  task automatic chk_run(input string t, input int ecyc, input int ny);
    check({t, "_done"}, 32'(r_done), ny == 5 ? 1 : 0);
    check({t, "_first"}, 32'(r_first_bad), 0);
    check({t, "_stable"}, 32'(r_stab_bad), 0);
    check({t, "_recv_gate"}, 32'(r_recv_bad), 0);
    check({t, "_y_in_send"}, 32'(r_ysend_bad), 0);
    check({t, "_ny"}, 32'(r_y), 32'(ny));
    check({t, "_nx"}, 32'(r_xi), 8);
    check({t, "_nf"}, 32'(r_fi), 4);
    if (ecyc >= 0) begin
      check({t, "_cycles"}, 32'(r_cyc), 32'(ecyc));
      check({t, "_busy_len"}, 32'(r_busy), 32'(ecyc));
    end else if (ny == 5) check({t, "_cycles"}, 32'(r_cyc), 32'(r_busy));
    for (int i = 0; i < 8; i++) check($sformatf("%s_x%0d", t, i), 32'(rx_x[i]), 32'(xv[i]));
    for (int i = 0; i < 4; i++) check($sformatf("%s_f%0d", t, i), 32'(rx_f[i]), 32'(fv[i]));
  endtask
  task automatic chk_reset_outs(input string t);
    check({t, "_busy"}, 32'(busy), 0);
    check({t, "_done"}, 32'(done), 0);
    check({t, "_cycles"}, 32'(cycles), 0);
    check({t, "_vx"}, 32'(m_valid_x), 0);
    check({t, "_vf"}, 32'(m_valid_f), 0);
    check({t, "_ry"}, 32'(m_ready_y), 0);
    check({t, "_dx"}, 32'(m_data_x), 0);
    check({t, "_df"}, 32'(m_data_f), 0);
  endtask
  initial begin
    checks = 0; failures = 0;
    reset_n = 0; ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; start = 0; rd_addr = 0;
    s_ready_x = 0; s_ready_f = 0; s_valid_y = 0; s_data_y = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    check("rst_rd", 32'(rd_data), 0);
    @(negedge clk);
    reset_n = 1;
    // Run 1: identity filter, with ignored loads and an ignored start during RECV.
    for (int i = 0; i < 8; i++) xv[i] = 8'(i + 1);
    fv[0] = 1; fv[1] = 0; fv[2] = 0; fv[3] = 0;
    for (int i = 0; i < 5; i++) yv[i] = 18'(i + 1);
    load_all();
    ld(1, 5, 8'h77);
    run(0, 5, 1, 0);
    chk_run("t1", 13, 5);
    @(negedge clk);
    #1;
    check("t1_done_once", 32'(done), 0);
    check("t1_idle", 32'(busy), 0);
    check("t1_cycles_held", 32'(cycles), 13);
    for (int i = 0; i < 5; i++) rdc($sformatf("t1_y%0d", i), i, 18'(i + 1));
    // Run 2 with backpressure and gapped y, then run 3 back-to-back.
    run(1, 5, 0, 1);
    chk_run("t2", -1, 5);
    for (int i = 0; i < 5; i++) yv[i] = 18'(10 * (i + 1));
    run(0, 5, 0, 0);
    chk_run("t3", 13, 5);
    for (int i = 0; i < 5; i++) rdc($sformatf("t3_y%0d", i), i, 18'(10 * (i + 1)));
    // Run 4: reset mid-RECV after two results.
    yv[0] = 18'h3_0007; yv[1] = 18'h0_0808; yv[2] = 9; yv[3] = 10; yv[4] = 11;
    run(0, 2, 0, 0);
    chk_run("t4", -1, 2);
    check("t4_in_recv", 32'(m_ready_y), 1);
    rdc("t4_y0", 0, 18'h3_0007);
    rdc("t4_y1", 1, 18'h0_0808);
    #1 reset_n = 0;
    #1;
    chk_reset_outs("t4r");
    for (int i = 0; i < 5; i++) begin
      rd_addr = 3'(i);
      #0.1 check($sformatf("t4r_y%0d", i), 32'(rd_data), 0);
    end
    @(negedge clk);
    reset_n = 1;
    // Run 5: fresh run after reset with new vectors.
    xv[0] = 3; xv[1] = 1; xv[2] = 4; xv[3] = 1; xv[4] = 5; xv[5] = 9; xv[6] = 2; xv[7] = 6;
    fv[0] = 2; fv[1] = 7; fv[2] = 1; fv[3] = 8;
    for (int i = 0; i < 5; i++) yv[i] = 18'(100 + i);
    load_all();
    run(0, 5, 0, 0);
    chk_run("t5", 13, 5);
    for (int i = 0; i < 5; i++) rdc($sformatf("t5_y%0d", i), i, 18'(100 + i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_stream_driver.md
# conv_stream_driver

Stream source and sink for the 1-D convolution core: holds one data vector (DATA_N samples) and one filter vector (FILTER_N taps) loaded by a host port, transmits them over the core's x and f valid/ready input channels, then collects the CONV_N results from the core's y output channel into a readable result buffer. Sits between the host/testbench register interface and the convolution top level, driving the slave side of the core's input channels and acting as the ready-issuing sink for its output channel. Also reports the total run latency in cycles.

## Interface
- DATA_N, 8, data vector length
- LG_DATA_N, 3, log2(DATA_N)
- FILTER_N, 4, filter vector length
- LG_FILTER_N, 2, log2(FILTER_N)
- CONV_N, 5, number of results (DATA_N - FILTER_N + 1)
- LG_CONV_N, 3, ceil(log2(CONV_N))
- DATA_W, 8, width of x and f samples
- Y_W, 18, width of a result
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ld_en  in  1  host write strobe into the vector buffers
- ld_sel  in  1  0 = x buffer, 1 = f buffer
- ld_addr  in  LG_DATA_N  buffer index
- ld_data  in  DATA_W  sample/tap value
- start  in  1  begin a run (sampled in IDLE only)
- busy  out  1  high in SEND and RECV
- done  out  1  one-cycle pulse at end of run
- cycles  out  16  cycles from start acceptance to done, held until next start
- m_valid_x / m_data_x  out  1 / DATA_W  x channel to the core
- s_ready_x  in  1  core accepts x
- m_valid_f / m_data_f  out  1 / DATA_W  f channel to the core
- s_ready_f  in  1  core accepts f
- s_valid_y / s_data_y  in  1 / Y_W  result channel from the core
- m_ready_y  out  1  driver accepts a result
- rd_addr  in  LG_CONV_N  result buffer read index
- rd_data  out  Y_W  combinational read of result buffer

## Operation
- Buffers: x_buf[DATA_N], f_buf[FILTER_N], y_buf[CONV_N], all registers, cleared to 0 on reset.
- Load: when ld_en=1 in IDLE, write ld_data to x_buf[ld_addr] (ld_sel=0) or f_buf[ld_addr] (ld_sel=1). f writes with ld_addr >= FILTER_N, x writes with ld_addr >= DATA_N, and any ld_en outside IDLE are ignored.
- FSM states: IDLE, SEND, RECV, DONE.
  - IDLE -> SEND on start=1. Clears cnt_x, cnt_f, cnt_y, and cycles.
  - SEND: x and f channels run independently.
    - m_valid_x = (cnt_x < DATA_N), with m_data_x = x_buf[cnt_x]; cnt_x increments on m_valid_x & s_ready_x.
    - The f channel is identical, using cnt_f, FILTER_N, and f_buf.
    - SEND -> RECV in the cycle where both counts reach their totals, counting a beat completing in that same cycle.
  - RECV: m_ready_y = 1. On s_valid_y & m_ready_y, y_buf[cnt_y] <= s_data_y and cnt_y increments. RECV -> DONE on the beat where cnt_y == CONV_N-1.
  - DONE: done = 1 for exactly one cycle, then -> IDLE.
- Counter widths: cnt_x is LG_DATA_N+1 bits, cnt_f is LG_FILTER_N+1 bits, cnt_y is LG_CONV_N bits. No wrap occurs within a run.
- cycles increments every cycle in SEND and RECV. It saturates at 16'hFFFF.
- Handshake rules:
  - Once m_valid_x/f is asserted, it stays high and its data stays stable until accepted.
  - m_ready_y is 0 outside RECV. s_valid_y beats arriving in SEND are not consumed.
- start while busy or in DONE is ignored.
- Reset mid-run (reset_n low) immediately returns to IDLE, clears all buffers and counters, and drops all valids/ready.

## Timing
- Reset values: busy=0, done=0, cycles=0, m_valid_x=0, m_valid_f=0, m_ready_y=0, m_data_x=0, m_data_f=0, rd_data=0.
- start high at edge N: busy and m_valid_x/f are high from cycle N+1, presenting x_buf[0] and f_buf[0].
- Channel throughput: one beat per cycle per channel with ready held high. With no backpressure, SEND lasts DATA_N cycles (8).
- Latency: the last SEND beat at edge M gives RECV (m_ready_y=1) from cycle M+1. The last y beat at edge K gives done=1 in cycle K+1 and IDLE at K+2.
- Result buffer: the written y_buf value is visible on rd_data the cycle after its accepting edge.
- cycles is final when done is high.

## Test plan
- Load x = 1..8 and f = {1,0,0,0}; start; core model always ready and returns y_i = x_i. Required: x beats 1..8 and f beats 1,0,0,0 transmitted in order; y_buf = {1,2,3,4,5}; done pulses exactly once; cycles = 8 + 5 + idle gaps of the model.
- Random s_ready_x/s_ready_f backpressure (50%). Required: m_data is stable while valid & !ready; no beat is lost or duplicated; RECV is entered only after 8 x and 4 f beats.
- s_valid_y asserted during SEND. Required: m_ready_y=0, nothing is written; the beat is taken only after entry to RECV.
- ld_en with ld_sel=1, ld_addr=5 (f out of range), and ld_en during SEND. Required: buffers unchanged. start asserted during RECV is ignored; busy stays 1.
- reset_n pulled low mid-RECV after 2 results. Required: all outputs at reset values asynchronously, y_buf is all zero; a fresh run afterwards completes normally.
- Back-to-back runs (start in the cycle after done). Required: second run starts; cycles restarts at 0; y_buf is overwritten.
